weight_buffer_pingpong: RTL and testbench

Double-buffered (ping-pong) successor to the single-bank weight buffer. The write side fills one bank from the wide memory interface while the PE-side read path drains the other bank at RD_WIDTH granularity. Bank ownership is tracked by a commit/release handshake, so weight prefetch for layer N+1 overlaps compute on layer N. It sits between the memory-read DMA and the PE array weight inputs.

---
 rtl/weight_buffer_pingpong_pkg.sv | 18 +
 rtl/weight_bank_ram.sv | 23 ++
 rtl/weight_buffer_pingpong.sv | 133 +++++++++++++
 tb/tb_weight_buffer_pingpong.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_buffer_pingpong_pkg.sv
// Shared constants and width helpers for the ping-pong weight buffer.
// Lane-select width is derived from the write/read width ratio.
package weight_buffer_pingpong_pkg;

    function automatic int c_log_2(input int value);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) n = i + 1;
        end
        return n;
    endfunction

    function automatic int lane_sel_width(input int wr_width, input int rd_width);
        return c_log_2(wr_width / rd_width);
    endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// Simple dual-port bank RAM: one write port, one registered read port.
// No reset; contents are undefined until written.
module weight_bank_ram #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [(1 << ADDR_WIDTH)];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/weight_buffer_pingpong.sv
// Ping-pong weight buffer: write side fills one bank while the PE side
// drains the other; ownership moves via commit/release handshakes.
module weight_buffer_pingpong
    import weight_buffer_pingpong_pkg::*;
#(
    parameter int RD_WIDTH      = 16,
    parameter int WR_WIDTH      = 64,
    parameter int RD_ADDR_WIDTH = 7,
    parameter int WR_ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     write_req,
    input  logic [WR_ADDR_WIDTH-1:0] write_addr,
    input  logic [WR_WIDTH-1:0]      write_data,
    input  logic                     write_commit,
    output logic                     wr_bank_ready,
    output logic                     wr_overflow,
    input  logic                     read_req,
    input  logic [RD_ADDR_WIDTH-1:0] read_addr,
    input  logic                     read_release,
    output logic                     rd_bank_valid,
    output logic [RD_WIDTH-1:0]      read_data,
    output logic                     read_valid
);

    localparam int RATIO     = WR_WIDTH / RD_WIDTH;
    localparam int LANE_BITS = lane_sel_width(WR_WIDTH, RD_WIDTH);
    localparam int LSW       = (LANE_BITS > 0) ? LANE_BITS : 1;

    logic [1:0] full;
    logic [1:0] release_pending;
    logic       wr_sel;
    logic       rd_sel;
    logic       wr_ok;
    logic       commit_ok;
    logic       release_ok;
    logic       read_ok;

    assign wr_bank_ready = ~full[wr_sel] & ~release_pending[wr_sel];
    assign rd_bank_valid = full[rd_sel];
    assign wr_ok         = write_req & wr_bank_ready;
    assign commit_ok     = write_commit & wr_bank_ready;
    assign release_ok    = read_release & rd_bank_valid;
    assign read_ok       = read_req & rd_bank_valid;

    // A released bank stays full one extra cycle so in-flight reads finish.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full            <= 2'b00;
            release_pending <= 2'b00;
            wr_sel          <= 1'b0;
            rd_sel          <= 1'b0;
            wr_overflow     <= 1'b0;
        end else begin
            full <= (full & ~release_pending)
                  | (commit_ok ? (2'b01 << wr_sel) : 2'b00);
            release_pending <= release_ok ? (2'b01 << rd_sel) : 2'b00;
            if (commit_ok) wr_sel <= ~wr_sel;
            if (release_ok) rd_sel <= ~rd_sel;
            if ((write_req | write_commit) & ~wr_bank_ready) wr_overflow <= 1'b1;
        end
    end

    logic                     s1_valid;
    logic                     s1_bank;
    logic [WR_ADDR_WIDTH-1:0] s1_word;
    logic [LSW-1:0]           s1_lane;
    logic                     s2_valid;
    logic                     s2_bank;
    logic [LSW-1:0]           s2_lane;
    logic [LSW-1:0]           lane_in;
    logic [WR_WIDTH-1:0]      bank_q [2];
    logic [WR_WIDTH-1:0]      word;
    logic [RD_WIDTH-1:0]      lane_data;

    if (LANE_BITS == 0) begin : g_no_lane
        assign lane_in = '0;
    end else begin : g_lane
        assign lane_in = read_addr[LSW-1:0];
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        weight_bank_ram #(
            .WIDTH      (WR_WIDTH),
            .ADDR_WIDTH (WR_ADDR_WIDTH)
        ) u_ram (
            .clk     (clk),
            .wr_en   (wr_ok && (wr_sel == 1'(b))),
            .wr_addr (write_addr),
            .wr_data (write_data),
            .rd_en   (s1_valid && (s1_bank == 1'(b))),
            .rd_addr (s1_word),
            .rd_data (bank_q[b])
        );
    end

    assign word = bank_q[s2_bank];

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (s2_lane == LSW'(i)) lane_data = word[i*RD_WIDTH +: RD_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid   <= 1'b0;
            s1_bank    <= 1'b0;
            s1_word    <= '0;
            s1_lane    <= '0;
            s2_valid   <= 1'b0;
            s2_bank    <= 1'b0;
            s2_lane    <= '0;
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            s1_valid <= read_ok;
            if (read_ok) begin
                s1_bank <= rd_sel;
                s1_word <= read_addr[RD_ADDR_WIDTH-1 -: WR_ADDR_WIDTH];
                s1_lane <= lane_in;
            end
            s2_valid   <= s1_valid;
            s2_bank    <= s1_bank;
            s2_lane    <= s1_lane;
            read_valid <= s2_valid;
            if (s2_valid) read_data <= lane_data;
        end
    end

endmodule

// File: tb/tb_weight_buffer_pingpong.sv
// Bench for the ping-pong weight buffer: handshake table, directed
// overlap/release sequences, random traffic vs. a bank-level model.
module tb_weight_buffer_pingpong;

    localparam int RW  = 16;
    localparam int WW  = 64;
    localparam int RAW = 7;
    localparam int WAW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           resetn = 1'b1;
    logic           write_req, write_commit, read_req, read_release;
    logic [WAW-1:0] write_addr;
    logic [WW-1:0]  write_data;
    logic [RAW-1:0] read_addr;
    logic           wr_bank_ready, wr_overflow, rd_bank_valid, read_valid;
    logic [RW-1:0]  read_data;

    logic        r1_write_req, r1_write_commit, r1_read_req, r1_read_release;
    logic [4:0]  r1_write_addr, r1_read_addr;
    logic [31:0] r1_write_data, r1_read_data;
    logic        r1_wr_bank_ready, r1_wr_overflow, r1_rd_bank_valid, r1_read_valid;

    weight_buffer_pingpong #(
        .RD_WIDTH(RW), .WR_WIDTH(WW), .RD_ADDR_WIDTH(RAW), .WR_ADDR_WIDTH(WAW)
    ) dut (
        .clk(clk), .resetn(resetn),
        .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
        .write_commit(write_commit), .wr_bank_ready(wr_bank_ready),
        .wr_overflow(wr_overflow), .read_req(read_req), .read_addr(read_addr),
        .read_release(read_release), .rd_bank_valid(rd_bank_valid),
        .read_data(read_data), .read_valid(read_valid)
    );

    weight_buffer_pingpong #(
        .RD_WIDTH(32), .WR_WIDTH(32), .RD_ADDR_WIDTH(5), .WR_ADDR_WIDTH(5)
    ) dut_r1 (
        .clk(clk), .resetn(resetn),
        .write_req(r1_write_req), .write_addr(r1_write_addr),
        .write_data(r1_write_data), .write_commit(r1_write_commit),
        .wr_bank_ready(r1_wr_bank_ready), .wr_overflow(r1_wr_overflow),
        .read_req(r1_read_req), .read_addr(r1_read_addr),
        .read_release(r1_read_release), .rd_bank_valid(r1_rd_bank_valid),
        .read_data(r1_read_data), .read_valid(r1_read_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bank ownership flags and a queue of due read results.
    typedef struct {
        int            due;
        logic [RW-1:0] d;
    } exp_t;

    logic [WW-1:0] mem [2][32];
    logic [1:0]    m_full, m_pend;
    logic          m_ws, m_rs, m_ovf;
    logic [RW-1:0] m_last;
    int            ncyc = 0;
    exp_t          q[$];

    task automatic idle_in();
        write_req = 0; write_commit = 0; read_req = 0; read_release = 0;
        write_addr = '0; write_data = '0; read_addr = '0;
        r1_write_req = 0; r1_write_commit = 0; r1_read_req = 0;
        r1_read_release = 0; r1_write_addr = '0; r1_write_data = '0;
        r1_read_addr = '0;
    endtask

    task automatic cyc();
        logic       ready, rv, nws, nrs;
        logic [1:0] nf, np;
        exp_t       e;
        ready = !m_full[m_ws] && !m_pend[m_ws];
        rv    = m_full[m_rs];
        check("wr_bank_ready", wr_bank_ready, ready);
        check("rd_bank_valid", rd_bank_valid, rv);
        nf = m_full & ~m_pend;
        np = 2'b00;
        nws = m_ws;
        nrs = m_rs;
        if (read_req && rv) begin
            e.due = ncyc + 3;
            e.d   = mem[m_rs][read_addr[6:2]][int'(read_addr[1:0])*RW +: RW];
            q.push_back(e);
        end
        if (write_req) begin
            if (ready) mem[m_ws][write_addr] = write_data;
            else m_ovf = 1'b1;
        end
        if (write_commit) begin
            if (ready) begin
                nf[m_ws] = 1'b1;
                nws = !m_ws;
            end else m_ovf = 1'b1;
        end
        if (read_release && rv) begin
            np[m_rs] = 1'b1;
            nrs = !m_rs;
        end
        @(posedge clk);
        #1;
        ncyc++;
        m_full = nf; m_pend = np; m_ws = nws; m_rs = nrs;
        if (q.size() > 0 && q[0].due == ncyc) begin
            check("read_valid", read_valid, 1);
            check("read_data", read_data, q[0].d);
            m_last = q[0].d;
            void'(q.pop_front());
        end else begin
            check("read_valid_idle", read_valid, 0);
            check("read_data_hold", read_data, m_last);
        end
        check("wr_overflow", wr_overflow, m_ovf);
    endtask

    task automatic do_reset();
        idle_in();
        resetn = 1'b0;
        m_full = 0; m_pend = 0; m_ws = 0; m_rs = 0; m_ovf = 0; m_last = 0;
        q.delete();
        #1;
        check("rst_read_valid", read_valid, 0);
        check("rst_read_data", read_data, 0);
        check("rst_wr_ready", wr_bank_ready, 1);
        check("rst_rd_valid", rd_bank_valid, 0);
        check("rst_overflow", wr_overflow, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    typedef struct {
        logic wreq, commit, rreq, rel;
        logic e_ready, e_rv, e_ovf;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [15:0] v;
        tbl[0]  = '{0, 0, 0, 1, 1, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 1, 1, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 1, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 1, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{0, 1, 0, 0, 0, 1, 1};
        tbl[7]  = '{0, 0, 0, 1, 0, 1, 1};
        tbl[8]  = '{0, 0, 0, 0, 1, 1, 1};
        tbl[9]  = '{0, 0, 0, 1, 1, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 1, 0, 1};

        idle_in();
        #2;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            idle_in();
            write_req = tbl[i].wreq; write_commit = tbl[i].commit;
            read_req = tbl[i].rreq; read_release = tbl[i].rel;
            write_addr = 5'd3; write_data = 64'h1234_5678_9abc_def0;
            read_addr = 7'd9;
            cyc();
            check("tbl_wr_ready", wr_bank_ready, tbl[i].e_ready);
            check("tbl_rd_valid", rd_bank_valid, tbl[i].e_rv);
            check("tbl_overflow", wr_overflow, tbl[i].e_ovf);
        end

        // Fill bank0; last write shares its cycle with the commit.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            idle_in();
            v = 16'(i);
            write_req = 1; write_addr = 5'(i);
            write_data = {v, v, v, v} + 64'h0003_0002_0001_0000;
            write_commit = (i == 31);
            cyc();
        end

        // Drain bank0 back-to-back while filling bank1.
        for (int j = 0; j < 128; j++) begin
            idle_in();
            read_req = 1; read_addr = 7'(j);
            if (j % 4 == 0) begin
                write_req = 1; write_addr = 5'(j / 4);
                write_data = {$urandom, $urandom};
            end
            write_commit = (j == 127);
            cyc();
        end

        // Read in the release cycle, then rewrite the freed word.
        idle_in();
        read_req = 1; read_addr = 7'd5; read_release = 1;
        cyc();
        check("ready_1_after_release", wr_bank_ready, 0);
        idle_in();
        read_req = 1; read_addr = 7'd0;
        cyc();
        check("ready_2_after_release", wr_bank_ready, 1);
        idle_in();
        read_req = 1; read_addr = 7'd1;
        write_req = 1; write_addr = 5'd1; write_data = 64'hdead_beef_cafe_f00d;
        cyc();
        for (int k = 0; k < 4; k++) begin
            idle_in();
            cyc();
        end

        for (int n = 0; n < 3000; n++) begin
            idle_in();
            write_req = 1'($urandom_range(0, 1));
            write_addr = 5'($urandom);
            write_data = {$urandom, $urandom};
            write_commit = ($urandom_range(0, 19) == 0);
            read_req = ($urandom_range(0, 9) < 6);
            read_addr = 7'($urandom);
            read_release = ($urandom_range(0, 24) == 0);
            cyc();
        end

        // Reset while a read is in flight discards it.
        do_reset();
        idle_in();
        write_commit = 1;
        cyc();
        idle_in();
        read_req = 1; read_addr = 7'd6;
        cyc();
        idle_in();
        cyc();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            idle_in();
            cyc();
        end

        // Ratio-1 instance: fill, commit, read back-to-back.
        for (int i = 0; i < 32; i++) begin
            idle_in();
            v = 16'(i);
            r1_write_req = 1; r1_write_addr = 5'(i);
            r1_write_data = {v + 16'd1, v};
            r1_write_commit = (i == 31);
            @(posedge clk);
            #1;
        end
        check("r1_rd_valid", r1_rd_bank_valid, 1);
        for (int j = 0; j < 34; j++) begin
            idle_in();
            r1_read_req = (j < 32);
            r1_read_addr = 5'(j);
            @(posedge clk);
            #1;
            if (j >= 2) begin
                v = 16'(j - 2);
                check("r1_read_valid", r1_read_valid, 1);
                check("r1_read_data", r1_read_data, {v + 16'd1, v});
            end else begin
                check("r1_read_valid_early", r1_read_valid, 0);
            end
        end
        idle_in();
        @(posedge clk);
        #1;
        check("r1_read_valid_end", r1_read_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
